// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch group generator.
// Helpers take widths as arguments so one package serves every PC_W/FETCH_W build.
package fetch_pkg;

    localparam int FETCH_MAX_PC_W = 32;
    localparam int FETCH_MAX_W    = 8;

    typedef struct packed {
        logic [FETCH_MAX_PC_W-1:0] base;
        logic [FETCH_MAX_W-1:0]    mask;
    } fetch_entry_t;

    function automatic logic [FETCH_MAX_PC_W-1:0] align_pc(
        input logic [FETCH_MAX_PC_W-1:0] pc,
        input int unsigned               fetch_w
    );
        return pc & ~(FETCH_MAX_PC_W'(fetch_w) - FETCH_MAX_PC_W'(1));
    endfunction

    // Slots below the target's offset inside its aligned group are not real instructions.
    function automatic logic [FETCH_MAX_W-1:0] slot_mask(
        input logic [FETCH_MAX_PC_W-1:0] target,
        input int unsigned               fetch_w
    );
        logic [FETCH_MAX_W-1:0] m;
        int unsigned            off;
        off = int'(target & (FETCH_MAX_PC_W'(fetch_w) - FETCH_MAX_PC_W'(1)));
        m   = '0;
        for (int unsigned i = 0; i < FETCH_MAX_W; i++) begin
            m[i] = (i < fetch_w) && (i >= off);
        end
        return m;
    endfunction

endpackage

// File: rtl/fetch_group_fifo.sv
// Generic DEPTH-entry synchronous FIFO with flush; head is read combinationally.
module fetch_group_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);
    import fetch_pkg::*;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (!reset && !flush && do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_group_gen.sv
// N-wide aligned fetch PC generator feeding decode through a group FIFO.
// Optional FETCH_GROUP_PERF_EN adds saturating stall/flush counters.
module fetch_group_gen #(
    parameter int PC_W    = 8,
    parameter int FETCH_W = 2,
    parameter int DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    redirect_valid,
    input  logic [PC_W-1:0]         redirect_pc,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [FETCH_W*PC_W-1:0] out_pc,
    output logic [FETCH_W-1:0]      out_slot_valid
`ifdef FETCH_GROUP_PERF_EN
    ,
    output logic [31:0]             perf_stall_cnt,
    output logic [31:0]             perf_flush_cnt
`endif
);
    import fetch_pkg::*;

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = PC_W + FETCH_W;

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [FETCH_W-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] head_entry;
    logic [PC_W-1:0]    head_base;
    logic [FETCH_W-1:0] head_mask;
    logic               full, pop, push;

    assign out_valid = (fifo_count != '0);
    assign head_base = head_entry[ENTRY_W-1 -: PC_W];
    assign head_mask = head_entry[FETCH_W-1:0];

    always_comb begin
        full   = (fifo_count == CNT_W'(DEPTH));
        pop    = out_valid && out_ready && !redirect_valid;
        push   = !redirect_valid && (!full || pop);
        pc_d   = pc_q;
        mask_d = mask_q;
        if (redirect_valid) begin
            pc_d   = PC_W'(align_pc(FETCH_MAX_PC_W'(redirect_pc), FETCH_W));
            mask_d = FETCH_W'(slot_mask(FETCH_MAX_PC_W'(redirect_pc), FETCH_W));
        end else if (push) begin
            pc_d   = pc_q + PC_W'(FETCH_W);
            mask_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= '0;
            mask_q <= '1;
        end else begin
            pc_q   <= pc_d;
            mask_q <= mask_d;
        end
    end

    fetch_group_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .pop       (pop),
        .push_data ({pc_q, mask_q}),
        .head_data (head_entry),
        .count     (fifo_count)
    );

    // Slot PCs wrap independently; an empty FIFO shows all zeros.
    always_comb begin
        out_pc         = '0;
        out_slot_valid = '0;
        if (out_valid) begin
            out_slot_valid = head_mask;
            for (int i = 0; i < FETCH_W; i++) begin
                out_pc[i*PC_W +: PC_W] = head_base + PC_W'(i);
            end
        end
    end

`ifdef FETCH_GROUP_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (full && !pop && !redirect_valid && (perf_stall_q != '1))
            perf_stall_d = perf_stall_q + 32'd1;
        if (redirect_valid && (perf_flush_q != '1))
            perf_flush_d = perf_flush_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_group_gen.sv
// Bench for fetch_group_gen: directed vector table, a queue-based reference
// model under random traffic, and a PC_W=4 instance for wrap-around.
module tb_fetch_group_gen;

    localparam int PC_W    = 8;
    localparam int FETCH_W = 2;
    localparam int DEPTH   = 4;
    localparam int ALL     = (1 << FETCH_W) - 1;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    redirect_valid = 1'b0;
    logic [PC_W-1:0]         redirect_pc = '0;
    logic                    out_ready = 1'b0;
    logic                    out_valid;
    logic [FETCH_W*PC_W-1:0] out_pc;
    logic [FETCH_W-1:0]      out_slot_valid;
`ifdef FETCH_GROUP_PERF_EN
    logic [31:0]             perf_stall_cnt;
    logic [31:0]             perf_flush_cnt;
`endif

    logic       rv4 = 1'b0;
    logic [3:0] rpc4 = '0;
    logic       rdy4 = 1'b1;
    logic       ov4;
    logic [7:0] opc4;
    logic [1:0] osv4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_group_gen #(.PC_W(PC_W), .FETCH_W(FETCH_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_slot_valid (out_slot_valid)
`ifdef FETCH_GROUP_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    fetch_group_gen #(.PC_W(4), .FETCH_W(2), .DEPTH(4)) dut4 (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (rv4),
        .redirect_pc    (rpc4),
        .out_ready      (rdy4),
        .out_valid      (ov4),
        .out_pc         (opc4),
        .out_slot_valid (osv4)
`ifdef FETCH_GROUP_PERF_EN
        ,
        .perf_stall_cnt (),
        .perf_flush_cnt ()
`endif
    );

    // Reference model: a queue of {base, mask} groups plus the next group to fetch.
    typedef struct {
        int base;
        int mask;
    } grp_t;

    grp_t m_q[$];
    int   m_pc   = 0;
    int   m_mask = ALL;

    task automatic modelStep(input bit rst, input bit rv, input int rpc, input bit rdy);
        if (rst) begin
            m_q.delete();
            m_pc   = 0;
            m_mask = ALL;
        end else if (rv) begin
            m_q.delete();
            m_pc   = rpc - (rpc % FETCH_W);
            m_mask = 0;
            for (int i = 0; i < FETCH_W; i++)
                if (m_pc + i >= rpc) m_mask = m_mask | (1 << i);
        end else begin
            int sz = m_q.size();
            bit p  = (sz > 0) && rdy;
            if (p) void'(m_q.pop_front());
            if (sz < DEPTH || p) begin
                m_q.push_back('{base: m_pc, mask: m_mask});
                m_pc   = (m_pc + FETCH_W) % (1 << PC_W);
                m_mask = ALL;
            end
        end
    endtask

    function automatic void modelExpect(output logic ev, output logic [FETCH_W*PC_W-1:0] epc,
                                        output logic [FETCH_W-1:0] em);
        ev  = 1'b0;
        epc = '0;
        em  = '0;
        if (m_q.size() > 0) begin
            ev = 1'b1;
            em = FETCH_W'(m_q[0].mask);
            for (int i = 0; i < FETCH_W; i++)
                epc[i*PC_W +: PC_W] = PC_W'((m_q[0].base + i) % (1 << PC_W));
        end
    endfunction

    task automatic applyStimulus(input bit rst, input bit rv, input logic [PC_W-1:0] rpc, input bit rdy);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clk);
        modelStep(rst, rv, int'(rpc), rdy);
        #1;
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [FETCH_W*PC_W-1:0] epc,
                               input logic [FETCH_W-1:0] em);
        checkValue({name, ".valid"}, 32'(out_valid), 32'(ev));
        checkValue({name, ".pc"},    32'(out_pc),    32'(epc));
        checkValue({name, ".mask"},  32'(out_slot_valid), 32'(em));
    endtask

    typedef struct {
        bit        rst;
        bit        rv;
        logic [7:0] rpc;
        bit        rdy;
        logic      ev;
        logic [15:0] epc;
        logic [1:0] em;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input bit rst, input bit rv, input logic [7:0] rpc, input bit rdy,
                                   input logic ev, input logic [15:0] epc, input logic [1:0] em);
        vecs.push_back('{rst: rst, rv: rv, rpc: rpc, rdy: rdy, ev: ev, epc: epc, em: em});
    endfunction

    initial begin
        logic                    ev;
        logic [FETCH_W*PC_W-1:0] epc;
        logic [FETCH_W-1:0]      em;

        addVec(1, 0, 8'h00, 0, 0, 16'h0000, 2'b00);
        addVec(0, 0, 8'h00, 1, 1, 16'h0100, 2'b11);
        addVec(0, 0, 8'h00, 1, 1, 16'h0302, 2'b11);
        addVec(0, 0, 8'h00, 1, 1, 16'h0504, 2'b11);
        addVec(0, 0, 8'h00, 1, 1, 16'h0706, 2'b11);
        for (int k = 0; k < 6; k++) addVec(0, 0, 8'h00, 0, 1, 16'h0706, 2'b11);
        addVec(0, 0, 8'h00, 1, 1, 16'h0908, 2'b11);
        addVec(0, 0, 8'h00, 1, 1, 16'h0B0A, 2'b11);
        addVec(0, 0, 8'h00, 1, 1, 16'h0D0C, 2'b11);
        addVec(0, 0, 8'h00, 1, 1, 16'h0F0E, 2'b11);
        addVec(0, 0, 8'h00, 1, 1, 16'h1110, 2'b11);
        addVec(0, 1, 8'h15, 1, 0, 16'h0000, 2'b00);
        addVec(0, 0, 8'h00, 1, 1, 16'h1514, 2'b10);
        addVec(0, 0, 8'h00, 1, 1, 16'h1716, 2'b11);
        addVec(0, 0, 8'h00, 0, 1, 16'h1716, 2'b11);
        addVec(0, 0, 8'h00, 0, 1, 16'h1716, 2'b11);
        addVec(0, 1, 8'h40, 1, 0, 16'h0000, 2'b00);
        addVec(0, 0, 8'h00, 1, 1, 16'h4140, 2'b11);
        addVec(0, 0, 8'h00, 1, 1, 16'h4342, 2'b11);
        addVec(0, 1, 8'hFF, 1, 0, 16'h0000, 2'b00);
        addVec(0, 0, 8'h00, 1, 1, 16'hFFFE, 2'b10);
        addVec(0, 0, 8'h00, 1, 1, 16'h0100, 2'b11);
        for (int k = 0; k < 4; k++) addVec(0, 0, 8'h00, 0, 1, 16'h0100, 2'b11);
        addVec(1, 0, 8'h00, 0, 0, 16'h0000, 2'b00);
        addVec(0, 0, 8'h00, 1, 1, 16'h0100, 2'b11);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].rst, vecs[k].rv, vecs[k].rpc, vecs[k].rdy);
            checkOutput($sformatf("vec%0d", k), vecs[k].ev, vecs[k].epc, vecs[k].em);
        end

        // Random traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            bit rst = ($urandom_range(0, 59) == 0);
            bit rv  = ($urandom_range(0, 9) == 0);
            bit rdy = ($urandom_range(0, 2) != 0);
            applyStimulus(rst, rv, PC_W'($urandom), rdy);
            modelExpect(ev, epc, em);
            checkOutput($sformatf("rand%0d", n), ev, epc, em);
        end

`ifdef FETCH_GROUP_PERF_EN
        applyStimulus(1, 0, '0, 0);
        checkValue("perf.stall_reset", perf_stall_cnt, 32'd0);
        checkValue("perf.flush_reset", perf_flush_cnt, 32'd0);
        applyStimulus(0, 1, 8'h33, 0);
        for (int k = 0; k < 7; k++) applyStimulus(0, 0, '0, 0);
        checkValue("perf.stall_cnt", perf_stall_cnt, 32'd3);
        checkValue("perf.flush_cnt", perf_flush_cnt, 32'd1);
        applyStimulus(1, 0, '0, 0);
        checkValue("perf.stall_after_reset", perf_stall_cnt, 32'd0);
        checkValue("perf.flush_after_reset", perf_flush_cnt, 32'd0);
`endif

        // Narrow instance: redirect near the top of a 4-bit PC space.
        applyStimulus(1, 0, '0, 1);
        applyStimulus(0, 0, '0, 1);
        rv4  = 1'b1;
        rpc4 = 4'hE;
        applyStimulus(0, 0, '0, 1);
        checkValue("pc4.redirect_bubble", 32'(ov4), 32'd0);
        rv4 = 1'b0;
        applyStimulus(0, 0, '0, 1);
        checkValue("pc4.g0.valid", 32'(ov4), 32'd1);
        checkValue("pc4.g0.pc", 32'(opc4), 32'h0FE);
        checkValue("pc4.g0.mask", 32'(osv4), 32'd3);
        applyStimulus(0, 0, '0, 1);
        checkValue("pc4.g1.pc", 32'(opc4), 32'h010);
        applyStimulus(0, 0, '0, 1);
        checkValue("pc4.g2.pc", 32'(opc4), 32'h032);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
